// File: rtl/digest_tx_seq.sv
// Prints a latched 128-bit MD5 digest as 32 lowercase hex characters, plus an
// optional CR/LF, one byte at a time through a handshake-style UART transmitter.
module digest_tx_seq #(
    parameter int APPEND_CRLF = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] digest,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [7:0]   uart_byte,
    output logic         uart_send,
    input  logic         uart_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = (APPEND_CRLF != 0) ? 6'd33 : 6'd31;

    state_t         state_q;
    logic [5:0]     idx_q;
    logic [127:0]   shadow_q;
    logic [6:0]     nib_base;
    logic [3:0]     nib;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 0x57 + 10 = 0x61 ('a'), keeping the a-f range lowercase
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    always_comb begin
        nib_base  = 7'd127 - {idx_q[4:0], 2'b00};
        nib       = shadow_q[nib_base -: 4];
        uart_byte = hex_ascii(nib);
        if (idx_q == 6'd32) begin
            uart_byte = 8'h0D;
        end else if (idx_q == 6'd33) begin
            uart_byte = 8'h0A;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign uart_send = (state_q == S_ISSUE) & uart_sent;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shadow_q <= digest;
                        idx_q    <= '0;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (uart_sent) begin
                        state_q <= S_GAP;
                    end
                end
                // The transmitter still reports idle in this cycle; skip it.
                S_GAP: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (uart_sent) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 6'd1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digest_tx_seq.sv
// Directed bench for digest_tx_seq: two instances (with and without CR/LF) driven
// by a simple transmitter model that answers each send with a short busy period.
`timescale 1ns/1ps

module tb_digest_tx_seq;

  localparam int TX_L = 3;
  localparam logic [127:0] D0 = 128'h0123456789abcdeffedcba9876543210;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] digest;
  logic         start1, start0, sent1, sent0;
  logic         busy1, done1, send1, busy0, done0, send0;
  logic [7:0]   byte1, byte0;

  int   n_assert = 0;
  int   n_fail   = 0;
  bit   sel0 = 1'b0;
  bit   tx_force_low = 1'b0;
  int   tx_cnt = 0;
  int   done_cnt = 0;
  logic o_send = 1'b0, o_busy = 1'b0, o_done = 1'b0, o_sent = 1'b1;
  logic [7:0] o_byte = 8'h00;
  logic p_send = 1'b0, p_busy = 1'b0, p_sent = 1'b1, pp_send = 1'b0;
  logic [7:0] p_byte = 8'h00;
  logic [7:0] rxq[$];
  string exp_hex = "0123456789abcdeffedcba9876543210";

  always #5 clock = ~clock;

  digest_tx_seq #(.APPEND_CRLF(1)) dut (
    .clock(clock), .reset(reset), .digest(digest), .start(start1),
    .busy(busy1), .done(done1), .uart_byte(byte1), .uart_send(send1),
    .uart_sent(sent1)
  );

  digest_tx_seq #(.APPEND_CRLF(0)) dut0 (
    .clock(clock), .reset(reset), .digest(digest), .start(start0),
    .busy(busy0), .done(done0), .uart_byte(byte0), .uart_send(send0),
    .uart_sent(sent0)
  );

  task automatic chk(input string tag, input bit ok, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the transmitter model after the edge, observe at the falling edge.
  task automatic step();
    logic d;
    @(posedge clock);
    #1;
    if (tx_force_low) begin
      d = 1'b0;
    end else if (tx_cnt > TX_L) begin
      d = 1'b1;
      tx_cnt--;
    end else if (tx_cnt > 0) begin
      d = 1'b0;
      tx_cnt--;
    end else begin
      d = 1'b1;
    end
    if (sel0) begin
      sent0 = d;
      sent1 = 1'b1;
    end else begin
      sent1 = d;
      sent0 = 1'b1;
    end
    @(negedge clock);
    pp_send = p_send;
    p_send  = o_send;
    p_busy  = o_busy;
    p_sent  = o_sent;
    p_byte  = o_byte;
    o_send  = sel0 ? send0 : send1;
    o_busy  = sel0 ? busy0 : busy1;
    o_done  = sel0 ? done0 : done1;
    o_byte  = sel0 ? byte0 : byte1;
    o_sent  = d;
    chk("send_while_not_sent", (o_send & ~o_sent) === 1'b0, o_send & ~o_sent, 1'b0);
    if (o_busy && p_busy && !(p_sent && !p_send && !pp_send && rxq.size() > 0))
      chk("byte_stable", o_byte === p_byte, o_byte, p_byte);
    if (o_send) begin
      rxq.push_back(o_byte);
      tx_cnt = TX_L + 1;
    end
    if (o_done) done_cnt++;
  endtask

  task automatic run_to_done(input int budget, input string tag);
    int c;
    c = 0;
    while (!o_done && c < budget) begin
      step();
      c++;
    end
    chk(tag, o_done === 1'b1, o_done, 1'b1);
  endtask

  task automatic check_hex(input int base, input string tag);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      v = (base + i < rxq.size()) ? rxq[base + i] : 8'hxx;
      chk(tag, v === exp_hex[i], v, exp_hex[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] v;
    reset  = 1'b1;
    digest = D0;
    start1 = 1'b0;
    start0 = 1'b0;
    sent1  = 1'b1;
    sent0  = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", busy1 === 1'b0, busy1, 1'b0);
    chk("reset_done", done1 === 1'b0, done1, 1'b0);
    chk("reset_send", send1 === 1'b0, send1, 1'b0);
    chk("reset_byte", byte1 === 8'h30, byte1, 8'h30);
    step();
    step();
    chk("reset_held_send", o_send === 1'b0, o_send, 1'b0);
    reset = 1'b1;

    // Full message with CR/LF
    rxq.delete();
    done_cnt = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("t1_first_send_latency", o_send === 1'b1, o_send, 1'b1);
    chk("t1_busy", o_busy === 1'b1, o_busy, 1'b1);
    run_to_done(400, "t1_done_reached");
    chk("t1_byte_count", rxq.size() === 34, rxq.size(), 34);
    check_hex(0, "t1_hex_byte");
    v = (rxq.size() > 32) ? rxq[32] : 8'hxx;
    chk("t1_cr", v === 8'h0D, v, 8'h0D);
    v = (rxq.size() > 33) ? rxq[33] : 8'hxx;
    chk("t1_lf", v === 8'h0A, v, 8'h0A);
    step();
    chk("t1_busy_after", o_busy === 1'b0, o_busy, 1'b0);
    chk("t1_done_after", o_done === 1'b0, o_done, 1'b0);
    chk("t1_done_count", done_cnt === 1, done_cnt, 1);

    // Instance without CR/LF
    sel0 = 1'b1;
    tx_cnt = 0;
    rxq.delete();
    done_cnt = 0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t2_first_send", o_send === 1'b1, o_send, 1'b1);
    run_to_done(400, "t2_done_reached");
    chk("t2_byte_count", rxq.size() === 32, rxq.size(), 32);
    check_hex(0, "t2_hex_byte");
    v = (rxq.size() > 0) ? rxq[rxq.size() - 1] : 8'hxx;
    chk("t2_last_byte", v === 8'h30, v, 8'h30);
    step();
    chk("t2_busy_after", o_busy === 1'b0, o_busy, 1'b0);
    chk("t2_done_count", done_cnt === 1, done_cnt, 1);
    sel0 = 1'b0;
    tx_cnt = 0;
    step();

    // Transmitter held busy for 50 cycles after start
    rxq.delete();
    tx_force_low = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) step();
      chk("t3_send_held_low", o_send === 1'b0, o_send, 1'b0);
      chk("t3_busy_held", o_busy === 1'b1, o_busy, 1'b1);
    end
    tx_force_low = 1'b0;
    step();
    chk("t3_send_on_release", o_send === 1'b1, o_send, 1'b1);
    chk("t3_first_byte", o_byte === 8'h30, o_byte, 8'h30);
    run_to_done(400, "t3_done_reached");
    chk("t3_byte_count", rxq.size() === 34, rxq.size(), 34);
    check_hex(0, "t3_hex_byte");
    step();

    // Start held high; digest changes mid-message
    rxq.delete();
    done_cnt = 0;
    digest = D0;
    start1 = 1'b1;
    for (int c = 0; c < 200 && rxq.size() < 4; c++) step();
    chk("t4_reached_byte3", rxq.size() === 4, rxq.size(), 4);
    digest = '1;
    run_to_done(400, "t4_first_done");
    chk("t4_done_count", done_cnt === 1, done_cnt, 1);
    chk("t4_first_count", rxq.size() === 34, rxq.size(), 34);
    check_hex(0, "t4_first_hex");
    step();
    chk("t4_idle_between", o_busy === 1'b0, o_busy, 1'b0);
    step();
    chk("t4_retrigger_send", o_send === 1'b1, o_send, 1'b1);
    chk("t4_retrigger_byte", o_byte === 8'h66, o_byte, 8'h66);
    start1 = 1'b0;
    run_to_done(400, "t4_second_done");
    chk("t4_total_count", rxq.size() === 68, rxq.size(), 68);
    for (int i = 34; i < 66; i++) begin
      v = (i < rxq.size()) ? rxq[i] : 8'hxx;
      chk("t4_second_f", v === 8'h66, v, 8'h66);
    end
    v = (rxq.size() > 66) ? rxq[66] : 8'hxx;
    chk("t4_second_cr", v === 8'h0D, v, 8'h0D);
    v = (rxq.size() > 67) ? rxq[67] : 8'hxx;
    chk("t4_second_lf", v === 8'h0A, v, 8'h0A);
    step();

    // Reset during byte 5
    rxq.delete();
    digest = D0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 0; c < 200 && rxq.size() < 6; c++) step();
    chk("t5_send_before_reset", o_send === 1'b1, o_send, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_send", send1 === 1'b0, send1, 1'b0);
    chk("t5_async_busy", busy1 === 1'b0, busy1, 1'b0);
    chk("t5_async_byte", byte1 === 8'h30, byte1, 8'h30);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_reset_no_send", o_send === 1'b0, o_send, 1'b0);
    end
    chk("t5_sends_before_reset", rxq.size() === 6, rxq.size(), 6);
    reset = 1'b1;
    tx_cnt = 0;
    rxq.delete();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("t5_start_after_reset", o_send === 1'b1, o_send, 1'b1);
    run_to_done(400, "t5_done_reached");
    chk("t5_byte_count", rxq.size() === 34, rxq.size(), 34);
    check_hex(0, "t5_hex_byte");
    step();
    chk("t5_busy_after", o_busy === 1'b0, o_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/digest_tx_seq.md
DIGEST_TX_SEQ -- requirements
Module: digest_tx_seq

Interface
REQ-001 SHALL have parameter APPEND_CRLF, default 1: when 1, append CR (0x0D) then LF (0x0A) after the hex digits.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port digest, input, 128 bits: the MD5 digest to print.
REQ-005 SHALL have port start, input, 1 bit: message request, sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a message.
REQ-008 SHALL have port uart_byte, output, 8 bits: byte to the transmitter's bytetosend.
REQ-009 SHALL have port uart_send, output, 1 bit: drives the transmitter's send.
REQ-010 SHALL have port uart_sent, input, 1 bit: the transmitter's sent (idle) flag.

Function
REQ-011 SHALL use five states: IDLE, ISSUE, GAP, WAIT, DONE.
REQ-012 SHALL, in IDLE with start=1, latch digest into a 128-bit shadow register, clear the byte index to 0, and enter ISSUE on the next edge.
REQ-013 SHALL ignore start in every state other than IDLE; a start held high re-triggers a new message once IDLE is re-entered.
REQ-014 SHALL send the message length as 32 bytes, plus 2 when APPEND_CRLF=1; the byte index is 6 bits wide.
REQ-015 SHALL map byte index i (i = 0..31) to shadow nibble [127-4i -: 4], most significant nibble first.
REQ-016 SHALL encode each nibble as lowercase ASCII: 0-9 become 0x30-0x39, a-f become 0x61-0x66.
REQ-017 SHALL output index 32 as 0x0D and index 33 as 0x0A.
REQ-018 SHALL drive uart_byte combinationally from the shadow register and the index.
REQ-019 SHALL hold uart_byte constant from ISSUE entry until WAIT exits for that byte, because the transmitter samples bytetosend live during each bit.
REQ-020 SHALL drive uart_send = (state==ISSUE) & uart_sent; it is never high while uart_sent=0 and never high outside ISSUE.
REQ-021 SHALL, in ISSUE, stay in ISSUE with uart_send=0 while uart_sent=0, and move to GAP on the edge where uart_send=1.
REQ-022 SHALL produce exactly one uart_send cycle per byte.
REQ-023 SHALL spend exactly one cycle in GAP, covering the cycle in which the transmitter leaves idle, then enter WAIT.
REQ-024 SHALL, in WAIT, stay while uart_sent=0.
REQ-025 SHALL, in WAIT with uart_sent=1 and index < last, increment the index and enter ISSUE.
REQ-026 SHALL, in WAIT with uart_sent=1 and index = last, enter DONE.
REQ-027 SHALL, in DONE, assert done for one cycle and then enter IDLE.
REQ-028 SHALL give the first uart_send a latency of 1 cycle after the start-sampling edge, given uart_sent=1.
REQ-029 SHALL leave 2 cycles between a byte's completion (uart_sent=1 seen in WAIT) and the next uart_send.
REQ-030 SHALL NOT let changes on digest after latching affect the message in flight.

Reset
REQ-031 SHALL, on reset=0 (immediately, without waiting for clock), set state to IDLE, the index to 0, and the shadow register to 0.
REQ-032 SHALL hold busy=0, done=0 and uart_send=0 while in reset.
REQ-033 SHALL, on a mid-message reset, abandon the message with no further uart_send; the transmitter's own reset handles its line state.
REQ-034 SHALL accept start on the first clock edge after reset deasserts.

Verification
REQ-035 Bench SHALL cover: digest 0x0123456789abcdeffedcba9876543210, APPEND_CRLF=1, start pulse -> exactly 34 uart_send pulses carrying "0123456789abcdeffedcba9876543210" then 0x0D, 0x0A; done pulses once; busy low afterwards.
REQ-036 Bench SHALL cover: same digest, APPEND_CRLF=0 -> exactly 32 pulses, last byte 0x30, then done.
REQ-037 Bench SHALL cover: uart_sent forced 0 for 50 cycles after start -> uart_send stays 0 and the state stays ISSUE; first pulse comes in the cycle uart_sent returns to 1.
REQ-038 Bench SHALL cover: start held high, digest changed to all-ones after byte 3 -> first message matches the original digest, done pulses, then a second message of all 0x66 ('f') begins.
REQ-039 Bench SHALL cover: reset asserted during byte 5 -> busy and uart_send drop asynchronously, no more sends; after release, a start pulse produces the full message from index 0.
REQ-040 Bench SHALL cover: continuous checkers -> uart_byte stable from ISSUE through WAIT exit, and uart_send never high while uart_sent=0, for every byte.
